id_ex_stage: RTL

Decode-to-execute pipeline register for the RV32 core; sits directly upstream of the shift unit and the ALU. It captures decoded instruction fields under a valid/ready handshake and resolves operand bypass from MEM and WB. It selects register or immediate for the second operand and drives the shift unit's operand and control inputs (Src1, 6-bit Src2, funct3_2, funct7_5, En) from a registered, flushable stage.

---
 rtl/id_ex_stage_pkg.sv | 29 ++
 rtl/id_ex_stage_fwd_mux.sv | 41 ++++
 rtl/id_ex_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared core definitions for the ID/EX stage: datapath width, unit-select encodings, payload layout.
package id_ex_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned UNIT_W = 2;
    localparam int unsigned F3_W   = 3;

    localparam logic [REG_AW-1:0] REG_ZERO   = REG_AW'(0);
    localparam logic [UNIT_W-1:0] UNIT_NONE  = 2'b00;
    localparam logic [UNIT_W-1:0] UNIT_ALU   = 2'b01;
    localparam logic [UNIT_W-1:0] UNIT_SHIFT = 2'b10;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [F3_W-1:0]   funct3;
        logic              funct7_5;
        logic [REG_AW-1:0] rd_addr;
        logic [UNIT_W-1:0] unit;
    } ex_payload_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand bypass select (MEM over WB over register file, x0 forced to zero).
// Bypass is compiled in only when FORWARDING_EN is defined.
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   data_c
);

`ifdef FORWARDING_EN
    always_comb begin
        data_c = rf_data;
        if (rs_addr == REG_ZERO) begin
            data_c = '0;
        end else if (mem_we && (mem_addr == rs_addr)) begin
            data_c = mem_data;
        end else if (wb_we && (wb_addr == rs_addr)) begin
            data_c = wb_data;
        end
    end
`else
    // Bypass sources are present but intentionally ignored in this build.
    logic unused_bypass;
    assign unused_bypass = ^{mem_we, mem_addr, mem_data, wb_we, wb_addr, wb_data};

    always_comb begin
        data_c = rf_data;
        if (rs_addr == REG_ZERO) begin
            data_c = '0;
        end
    end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand bypass and shift-unit drive.
// Optional MEM/WB bypass enabled by defining FORWARDING_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_src2_imm,
    input  logic [UNIT_W-1:0] id_unit,
    input  logic [F3_W-1:0]   id_funct3,
    input  logic              id_funct7_5,
    input  logic              mem_fwd_we,
    input  logic              wb_fwd_we,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]   mem_rd_data,
    input  logic [XLEN-1:0]   wb_rd_data,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_src1,
    output logic [XLEN-1:0]   ex_src2,
    output logic [XLEN-1:0]   shift_src1,
    output logic [5:0]        shift_src2,
    output logic              shift_funct3_2,
    output logic              shift_funct7_5,
    output logic              shift_en,
    output logic              alu_en,
    output logic [F3_W-1:0]   ex_funct3,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic [XLEN-1:0]   ex_pc
);

    stage_state_e state_q, state_d;
    ex_payload_t  pay_q, pay_d;
    logic         shift_en_q, shift_en_d;
    logic         alu_en_q, alu_en_d;
    logic [XLEN-1:0] rs1_byp_c, rs2_byp_c;

    id_ex_stage_fwd_mux u_fwd_rs1 (
        .rs_addr (id_rs1_addr),
        .rf_data (id_rs1_data),
        .mem_we  (mem_fwd_we),
        .mem_addr(mem_rd_addr),
        .mem_data(mem_rd_data),
        .wb_we   (wb_fwd_we),
        .wb_addr (wb_rd_addr),
        .wb_data (wb_rd_data),
        .data_c  (rs1_byp_c)
    );

    id_ex_stage_fwd_mux u_fwd_rs2 (
        .rs_addr (id_rs2_addr),
        .rf_data (id_rs2_data),
        .mem_we  (mem_fwd_we),
        .mem_addr(mem_rd_addr),
        .mem_data(mem_rd_data),
        .wb_we   (wb_fwd_we),
        .wb_addr (wb_rd_addr),
        .wb_data (wb_rd_data),
        .data_c  (rs2_byp_c)
    );

    // Single-entry stage: accept whenever empty or draining this cycle.
    assign id_ready = (state_q == ST_EMPTY) | ex_ready;

    always_comb begin
        state_d = state_q;
        pay_d   = pay_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (id_valid && id_ready) begin
            state_d        = ST_FULL;
            pay_d.pc       = id_pc;
            pay_d.src1     = rs1_byp_c;
            pay_d.src2     = id_src2_imm ? id_imm : rs2_byp_c;
            pay_d.funct3   = id_funct3;
            pay_d.funct7_5 = id_funct7_5;
            pay_d.rd_addr  = id_rd_addr;
            pay_d.unit     = id_unit;
        end else if ((state_q == ST_FULL) && ex_ready) begin
            state_d = ST_EMPTY;
        end
        shift_en_d = (state_d == ST_FULL) && (pay_d.unit == UNIT_SHIFT);
        alu_en_d   = (state_d == ST_FULL) && (pay_d.unit == UNIT_ALU);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            pay_q      <= '0;
            shift_en_q <= 1'b0;
            alu_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pay_q      <= pay_d;
            shift_en_q <= shift_en_d;
            alu_en_q   <= alu_en_d;
        end
    end

    assign ex_valid       = (state_q == ST_FULL);
    assign ex_src1        = pay_q.src1;
    assign ex_src2        = pay_q.src2;
    assign ex_funct3      = pay_q.funct3;
    assign ex_rd_addr     = pay_q.rd_addr;
    assign ex_pc          = pay_q.pc;
    assign shift_src1     = pay_q.src1;
    assign shift_src2     = {1'b0, pay_q.src2[4:0]};
    assign shift_funct3_2 = pay_q.funct3[2];
    assign shift_funct7_5 = pay_q.funct7_5;
    assign shift_en       = shift_en_q;
    assign alu_en         = alu_en_q;

endmodule
